// File: rtl/wb_cmd_master_pkg.sv
// Shared types and helpers for the Wishbone command initiator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package wb_cmd_master_pkg;

    // FSM encoding, kept as plain constants so older tools and dumps stay readable
    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t BUS  = 2'd1;
    localparam state_t RESP = 2'd2;

    localparam int BYTE_W = 8;

    // Byte-select width for a given data width
    function automatic int sel_width(input int dw);
        return dw / BYTE_W;
    endfunction

    // Ceiling log2, used to size the ack-wait counter for TIMEOUT_CYCLES+1 values
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/wb_cmd_timeout.sv
// Ack-wait counter: cleared on command accept, counts BUS cycles without ack.
// Latency: tc reflects the registered count, usable in the same cycle.
// Backpressure: none; saturates at LIMIT so it never wraps while stalled.
module wb_cmd_timeout #(
    parameter int CW    = 8,
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);
    localparam logic [CW-1:0] MAX  = CW'(LIMIT);

    logic [CW-1:0] cnt;

    // Count idle BUS cycles; clear wins over enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != MAX)) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Terminal cycle: this is the LIMIT-th BUS cycle without ack
    assign tc = (cnt == LAST);

endmodule

// File: rtl/wb_cmd_master.sv
// Wishbone classic single-transfer initiator driven by a valid/ready command port.
// Latency: cyc/stb one cycle after accept; response the cycle after ack (or timeout).
// Backpressure: one command in flight; response held until taken. Timeout via WB_CMD_TIMEOUT_EN.
module wb_cmd_master
    import wb_cmd_master_pkg::*;
#(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_ni,
    input  logic            cmd_valid_i,
    output logic            cmd_ready_o,
    input  logic            cmd_we_i,
    input  logic [AW-1:0]   cmd_adr_i,
    input  logic [DW-1:0]   cmd_dat_i,
    input  logic [DW/8-1:0] cmd_sel_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [DW-1:0]   rsp_dat_o,
    output logic            rsp_err_o,
    output logic            wbm_cyc_o,
    output logic            wbm_stb_o,
    output logic            wbm_we_o,
    output logic [DW/8-1:0] wbm_sel_o,
    output logic [AW-1:0]   wbm_adr_o,
    output logic [DW-1:0]   wbm_dat_o,
    input  logic [DW-1:0]   wbm_dat_i,
    input  logic            wbm_ack_i,
    output logic            busy_o
);

    localparam int SW = sel_width(DW);

    // Reject unusable configurations at elaboration
    if ((SW * BYTE_W != DW) || (TIMEOUT_CYCLES < 1)) begin : g_bad_param
        $error("wb_cmd_master: DW must be a multiple of 8 and TIMEOUT_CYCLES >= 1");
    end

    state_t state;
    logic   accept;
    logic   timeout_hit;

    assign accept = (state == IDLE) && cmd_ready_o && cmd_valid_i;

`ifdef WB_CMD_TIMEOUT_EN
    localparam int CW = clog2(TIMEOUT_CYCLES + 1);

    logic tmo_tc;

    wb_cmd_timeout #(
        .CW    (CW),
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_ni),
        .clr   (accept),
        .en    ((state == BUS) && !wbm_ack_i),
        .tc    (tmo_tc)
    );

    // Ack in the terminal cycle takes precedence over the timeout
    assign timeout_hit = (state == BUS) && !wbm_ack_i && tmo_tc;
`else
    assign timeout_hit = 1'b0;
`endif

    // Single FSM; every output is a register updated alongside the state
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state       <= IDLE;
            cmd_ready_o <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_dat_o   <= '0;
            rsp_err_o   <= 1'b0;
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            wbm_we_o    <= 1'b0;
            wbm_sel_o   <= '0;
            wbm_adr_o   <= '0;
            wbm_dat_o   <= '0;
            busy_o      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state       <= BUS;
                        cmd_ready_o <= 1'b0;
                        busy_o      <= 1'b1;
                        wbm_cyc_o   <= 1'b1;
                        wbm_stb_o   <= 1'b1;
                        wbm_we_o    <= cmd_we_i;
                        wbm_adr_o   <= cmd_adr_i;
                        wbm_dat_o   <= cmd_dat_i;
                        wbm_sel_o   <= cmd_sel_i;
                    end else begin
                        cmd_ready_o <= 1'b1;
                    end
                end
                BUS: begin
                    if (wbm_ack_i) begin
                        state       <= RESP;
                        wbm_cyc_o   <= 1'b0;
                        wbm_stb_o   <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        rsp_dat_o   <= wbm_we_o ? '0 : wbm_dat_i;
                        rsp_err_o   <= 1'b0;
                    end else if (timeout_hit) begin
                        state       <= RESP;
                        wbm_cyc_o   <= 1'b0;
                        wbm_stb_o   <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        rsp_dat_o   <= '0;
                        rsp_err_o   <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        state       <= IDLE;
                        rsp_valid_o <= 1'b0;
                        busy_o      <= 1'b0;
                        cmd_ready_o <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    cmd_ready_o <= 1'b0;
                    busy_o      <= 1'b0;
                    wbm_cyc_o   <= 1'b0;
                    wbm_stb_o   <= 1'b0;
                    rsp_valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed self-checking bench for wb_cmd_master.
// Timing: inputs driven and outputs sampled 1ns after each rising edge.
// Timeout cases compile in only when WB_CMD_TIMEOUT_EN is defined.
module tb_wb_cmd_master;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          wb_clk_i;
    logic          wb_rst_ni;
    logic          cmd_valid_i;
    logic          cmd_ready_o;
    logic          cmd_we_i;
    logic [AW-1:0] cmd_adr_i;
    logic [DW-1:0] cmd_dat_i;
    logic [3:0]    cmd_sel_i;
    logic          rsp_valid_o;
    logic          rsp_ready_i;
    logic [DW-1:0] rsp_dat_o;
    logic          rsp_err_o;
    logic          wbm_cyc_o;
    logic          wbm_stb_o;
    logic          wbm_we_o;
    logic [3:0]    wbm_sel_o;
    logic [AW-1:0] wbm_adr_o;
    logic [DW-1:0] wbm_dat_o;
    logic [DW-1:0] wbm_dat_i;
    logic          wbm_ack_i;
    logic          busy_o;

    int checks = 0;
    int errors = 0;

    wb_cmd_master #(
        .AW             (AW),
        .DW             (DW),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_ni   (wb_rst_ni),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_we_i    (cmd_we_i),
        .cmd_adr_i   (cmd_adr_i),
        .cmd_dat_i   (cmd_dat_i),
        .cmd_sel_i   (cmd_sel_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_dat_o   (rsp_dat_o),
        .rsp_err_o   (rsp_err_o),
        .wbm_cyc_o   (wbm_cyc_o),
        .wbm_stb_o   (wbm_stb_o),
        .wbm_we_o    (wbm_we_o),
        .wbm_sel_o   (wbm_sel_o),
        .wbm_adr_o   (wbm_adr_o),
        .wbm_dat_o   (wbm_dat_o),
        .wbm_dat_i   (wbm_dat_i),
        .wbm_ack_i   (wbm_ack_i),
        .busy_o      (busy_o)
    );

    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic drive_cmd(input logic we, input logic [AW-1:0] adr,
                             input logic [DW-1:0] dat, input logic [3:0] sel);
        cmd_valid_i = 1'b1;
        cmd_we_i    = we;
        cmd_adr_i   = adr;
        cmd_dat_i   = dat;
        cmd_sel_i   = sel;
    endtask

    initial begin
        wb_rst_ni   = 1'b0;
        cmd_valid_i = 1'b0;
        cmd_we_i    = 1'b0;
        cmd_adr_i   = '0;
        cmd_dat_i   = '0;
        cmd_sel_i   = '0;
        rsp_ready_i = 1'b0;
        wbm_dat_i   = '0;
        wbm_ack_i   = 1'b0;

        // ---- reset state ----
        #12;
        chk("rst_cmd_ready", cmd_ready_o, 0);
        chk("rst_cyc", wbm_cyc_o, 0);
        chk("rst_rsp_valid", rsp_valid_o, 0);
        chk("rst_busy", busy_o, 0);
        #11 wb_rst_ni = 1'b1;
        tick();
        chk("idle_cmd_ready", cmd_ready_o, 1);

        // ---- stray ack in IDLE ----
        wbm_ack_i = 1'b1;
        tick();
        wbm_ack_i = 1'b0;
        chk("stray_idle_ready", cmd_ready_o, 1);
        chk("stray_idle_cyc", wbm_cyc_o, 0);
        chk("stray_idle_rsp", rsp_valid_o, 0);
        chk("stray_idle_busy", busy_o, 0);

        // ---- write, ack in first BUS cycle ----
        drive_cmd(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF);
        tick();
        cmd_valid_i = 1'b0;
        chk("wr_cyc", wbm_cyc_o, 1);
        chk("wr_stb", wbm_stb_o, 1);
        chk("wr_we", wbm_we_o, 1);
        chk("wr_adr", wbm_adr_o, 32'h3000_0004);
        chk("wr_dat", wbm_dat_o, 32'hDEAD_BEEF);
        chk("wr_sel", wbm_sel_o, 4'hF);
        chk("wr_busy", busy_o, 1);
        chk("wr_ready_low", cmd_ready_o, 0);
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'hFFFF_0000;
        tick();
        wbm_ack_i = 1'b0;
        chk("wr_cyc_drop", wbm_cyc_o, 0);
        chk("wr_stb_drop", wbm_stb_o, 0);
        chk("wr_rsp_valid", rsp_valid_o, 1);
        chk("wr_rsp_dat", rsp_dat_o, 0);
        chk("wr_rsp_err", rsp_err_o, 0);
        chk("wr_adr_hold", wbm_adr_o, 32'h3000_0004);
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        chk("wr_rsp_taken", rsp_valid_o, 0);
        chk("wr_busy_done", busy_o, 0);
        chk("wr_ready_back", cmd_ready_o, 1);

        // ---- read, ack after 3 BUS cycles ----
        drive_cmd(1'b0, 32'h3000_0010, 32'h0, 4'h3);
        tick();
        cmd_valid_i = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            chk($sformatf("rd_cyc_%0d", i), wbm_cyc_o, 1);
            chk($sformatf("rd_busy_%0d", i), busy_o, 1);
            if (i == 3) begin
                wbm_ack_i = 1'b1;
                wbm_dat_i = 32'h1234_5678;
            end
            tick();
        end
        wbm_ack_i = 1'b0;
        wbm_dat_i = 32'h0BAD_0BAD;
        chk("rd_cyc_drop", wbm_cyc_o, 0);
        chk("rd_rsp_valid", rsp_valid_o, 1);
        chk("rd_rsp_dat", rsp_dat_o, 32'h1234_5678);
        chk("rd_rsp_err", rsp_err_o, 0);
        chk("rd_sel", wbm_sel_o, 4'h3);

        // ---- stray ack in RESP, then 5 cycles of backpressure with a queued command ----
        wbm_ack_i = 1'b1;
        drive_cmd(1'b1, 32'h3000_0020, 32'hCAFE_F00D, 4'h5);
        tick();
        wbm_ack_i = 1'b0;
        chk("stray_resp_valid", rsp_valid_o, 1);
        chk("stray_resp_dat", rsp_dat_o, 32'h1234_5678);
        chk("stray_resp_cyc", wbm_cyc_o, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("bp_valid_%0d", i), rsp_valid_o, 1);
            chk($sformatf("bp_dat_%0d", i), rsp_dat_o, 32'h1234_5678);
            chk($sformatf("bp_ready_%0d", i), cmd_ready_o, 0);
            chk($sformatf("bp_cyc_%0d", i), wbm_cyc_o, 0);
        end
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        chk("bp_rsp_taken", rsp_valid_o, 0);
        chk("bp_ready_back", cmd_ready_o, 1);
        chk("bp_not_started", wbm_cyc_o, 0);
        tick();
        cmd_valid_i = 1'b0;
        chk("q2_cyc", wbm_cyc_o, 1);
        chk("q2_adr", wbm_adr_o, 32'h3000_0020);
        chk("q2_dat", wbm_dat_o, 32'hCAFE_F00D);
        chk("q2_sel", wbm_sel_o, 4'h5);
        wbm_ack_i = 1'b1;
        tick();
        wbm_ack_i = 1'b0;
        chk("q2_rsp_valid", rsp_valid_o, 1);
        chk("q2_rsp_dat", rsp_dat_o, 0);
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;

        // ---- asynchronous reset in the middle of BUS ----
        drive_cmd(1'b0, 32'h3000_0030, 32'h0, 4'hF);
        tick();
        cmd_valid_i = 1'b0;
        chk("ar_cyc_pre", wbm_cyc_o, 1);
        #2 wb_rst_ni = 1'b0;
        #1;
        chk("ar_cyc", wbm_cyc_o, 0);
        chk("ar_stb", wbm_stb_o, 0);
        chk("ar_rsp_valid", rsp_valid_o, 0);
        chk("ar_busy", busy_o, 0);
        chk("ar_ready", cmd_ready_o, 0);
        #13 wb_rst_ni = 1'b1;
        tick();
        chk("ar_ready_after", cmd_ready_o, 1);
        chk("ar_no_rsp", rsp_valid_o, 0);
        drive_cmd(1'b0, 32'h3000_0040, 32'h0, 4'hF);
        tick();
        cmd_valid_i = 1'b0;
        chk("ar_rd_cyc", wbm_cyc_o, 1);
        chk("ar_rd_adr", wbm_adr_o, 32'h3000_0040);
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'hA5A5_0F0F;
        tick();
        wbm_ack_i = 1'b0;
        chk("ar_rd_valid", rsp_valid_o, 1);
        chk("ar_rd_dat", rsp_dat_o, 32'hA5A5_0F0F);
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;

`ifdef WB_CMD_TIMEOUT_EN
        // ---- timeout: no ack for 4 BUS cycles ----
        wbm_dat_i = 32'h7777_7777;
        drive_cmd(1'b0, 32'h3000_0050, 32'h0, 4'hF);
        tick();
        cmd_valid_i = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("to_cyc_%0d", i), wbm_cyc_o, 1);
            tick();
        end
        chk("to_cyc_drop", wbm_cyc_o, 0);
        chk("to_rsp_valid", rsp_valid_o, 1);
        chk("to_rsp_err", rsp_err_o, 1);
        chk("to_rsp_dat", rsp_dat_o, 0);
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;

        // ---- ack in the terminal cycle wins ----
        drive_cmd(1'b0, 32'h3000_0060, 32'h0, 4'hF);
        tick();
        cmd_valid_i = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("tt_cyc_%0d", i), wbm_cyc_o, 1);
            if (i == 4) begin
                wbm_ack_i = 1'b1;
                wbm_dat_i = 32'h0000_55AA;
            end
            tick();
        end
        wbm_ack_i = 1'b0;
        chk("tt_rsp_valid", rsp_valid_o, 1);
        chk("tt_rsp_err", rsp_err_o, 0);
        chk("tt_rsp_dat", rsp_dat_o, 32'h0000_55AA);
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
